hazard_unit: RTL
================

# hazard_unit

Pipeline hazard controller for the 5-stage MIPS core. Compares register IDs across the Decode (D), Execute (E), Memory (M) and Writeback (W) stages. From that comparison it produces:
- forwarding selects for the Decode-stage branch comparator and for the Execute-stage ALU operands;
- stall and flush controls for the pipeline registers.

It also sequences the fixed-latency multiply/divide unit through a busy FSM. It stalls any dependent instruction until HI/LO are valid.

## Interface
Parameters:
- MD_LAT, 4: multiply/divide latency in cycles (2..15).

Ports (clock and reset first):
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- rs_D, rt_D  in  5  source register IDs in D
- rs_E, rt_E  in  5  source register IDs in E
- reg_id_E, reg_id_M, reg_id_W  in  5  destination register IDs
- reg_write_E, reg_write_M, reg_write_W  in  1  destination will be written
- mem_to_reg_E, mem_to_reg_M  in  1  instruction is a load
- branch_D  in  1  beq in D
- jump_D  in  1  j in D
- pc_src_D  in  1  branch taken (from the decode datapath)
- md_start_E  in  1  mult/div issuing in E
- md_use_D  in  1  D instruction is mfhi/mflo/mult/div
- forwardA_D, forwardB_D  out  1  branch comparator takes alu_out_M
- forwardA_E, forwardB_E  out  2  ALU operand select: 00 regfile, 01 result_W, 10 alu_out_M
- stall_F, stall_D  out  1  hold PC / D pipeline register
- flush_D, flush_E  out  1  clear D / E pipeline register
- md_busy  out  1  mult/div unit in flight
- stall_cnt, flush_cnt  out  32  performance counters (see Configuration)

## Operation
Register 0 never matches in any comparison below.

Execute-stage forwarding (M has priority over W):
- forwardA_E = 10 if rs_E==reg_id_M && reg_write_M.
- Else forwardA_E = 01 if rs_E==reg_id_W && reg_write_W.
- Else forwardA_E = 00.
- forwardB_E uses the same rules with rt_E.

Decode-stage forwarding:
- forwardA_D = rs_D==reg_id_M && reg_write_M.
- forwardB_D = rt_D==reg_id_M && reg_write_M.

Stall conditions:
- lw_stall = mem_to_reg_E && (reg_id_E==rs_D || reg_id_E==rt_D).
- br_stall = branch_D && ((reg_write_E && reg_id_E∈{rs_D,rt_D}) || (mem_to_reg_M && reg_id_M∈{rs_D,rt_D})).
- md_stall = md_use_D && md_busy.
- stall = lw_stall | br_stall | md_stall.

Control outputs:
- stall_F = stall_D = stall.
- flush_E = stall, so a bubble is inserted behind the held instruction.
- flush_D = (pc_src_D | jump_D) && !stall. A stalled branch does not flush; it is evaluated again next cycle.

Multiply/divide FSM, states IDLE and BUSY, 4-bit down counter md_cnt:
- IDLE, md_start_E=1: go to BUSY, md_cnt ← MD_LAT-1.
- BUSY, md_cnt≠0: md_cnt decrements.
- BUSY, md_cnt==0: return to IDLE.
- md_busy = (state==BUSY).
- md_start_E while BUSY cannot occur, because md_stall holds the instruction in D. If it is asserted anyway, it is ignored and the counter is not reloaded.

## Timing
- Forwarding, stall and flush outputs are combinational from same-cycle inputs; zero latency.
- md_busy is registered. It rises the cycle after md_start_E and stays high exactly MD_LAT cycles.
- A dependent instruction in D is released in the first cycle md_busy=0.
- Simultaneous lw_stall and pc_src_D: stall wins; flush_D=0, flush_E=1.
- Reset:
  - state IDLE, md_cnt=0, md_busy=0, counters 0.
  - While reset=1: stall_F=stall_D=0 and flush_D=flush_E=1.
  - Reset during BUSY returns to IDLE on the next edge; the in-flight operation is abandoned.

## Configuration
Macro `HAZARD_PERF_EN`:
- Defined: stall_cnt increments every cycle stall=1, and flush_cnt every cycle flush_D=1. Both are 32-bit, wrap at 2^32-1 → 0, and clear on reset.
- Undefined: no counter logic; stall_cnt and flush_cnt are tied to 0.

## Test plan
- rs_E=5, reg_id_M=5, reg_write_M=1, reg_id_W=5, reg_write_W=1 → forwardA_E=10. Same with reg_write_M=0 → 01. rs_E=0 with all IDs 0 → 00.
- lw with reg_id_E=8 (mem_to_reg_E=1), rs_D=8 → stall_F=stall_D=flush_E=1 for one cycle. Next cycle (load now in M, D unchanged) → no stall.
- beq in D with rs_D=3, ALU op in E writing $3 → 1 stall cycle, then forwardA_D=1. Then pc_src_D=1 → flush_D=1, stall=0.
- MD_LAT=4, md_start_E pulse, then mfhi in D (md_use_D=1) → md_busy high for 4 cycles, stall_D high those 4 cycles, released on cycle 5.
- reset asserted in the 2nd BUSY cycle → md_busy=0 the next cycle, flush_D=flush_E=1 during reset, no stall.
- With HAZARD_PERF_EN defined: 3 stall cycles plus 1 jump → stall_cnt=3, flush_cnt=1. Preload stall_cnt near 2^32-1 via a long stall → wraps to 0.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding, stall/flush control and mult/div busy sequencing for the 5-stage MIPS pipeline.
// Optional feature macro: HAZARD_PERF_EN enables the stall/flush performance counters.
// Revision: 1.0
`default_nettype none

module hazard_unit #(
  parameter int MD_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [4:0]  rs_E,
  input  logic [4:0]  rt_E,
  input  logic [4:0]  reg_id_E,
  input  logic [4:0]  reg_id_M,
  input  logic [4:0]  reg_id_W,
  input  logic        reg_write_E,
  input  logic        reg_write_M,
  input  logic        reg_write_W,
  input  logic        mem_to_reg_E,
  input  logic        mem_to_reg_M,
  input  logic        branch_D,
  input  logic        jump_D,
  input  logic        pc_src_D,
  input  logic        md_start_E,
  input  logic        md_use_D,
  output logic        forwardA_D,
  output logic        forwardB_D,
  output logic [1:0]  forwardA_E,
  output logic [1:0]  forwardB_E,
  output logic        stall_F,
  output logic        stall_D,
  output logic        flush_D,
  output logic        flush_E,
  output logic        md_busy,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;
  localparam logic [3:0] C_MD_RELOAD = 4'(MD_LAT - 1);
  localparam logic [4:0] C_REG_ZERO  = 5'd0;

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;
  logic [3:0] r_md_cnt;
  logic [3:0] w_md_cnt_nxt;

  // Register-ID matches; $0 is hard-wired and never produces a hazard.
  logic w_m_rs_E, w_m_rt_E, w_w_rs_E, w_w_rt_E;
  logic w_m_rs_D, w_m_rt_D, w_e_rs_D, w_e_rt_D;

  assign w_m_rs_E = (reg_id_M != C_REG_ZERO) && (reg_id_M == rs_E);
  assign w_m_rt_E = (reg_id_M != C_REG_ZERO) && (reg_id_M == rt_E);
  assign w_w_rs_E = (reg_id_W != C_REG_ZERO) && (reg_id_W == rs_E);
  assign w_w_rt_E = (reg_id_W != C_REG_ZERO) && (reg_id_W == rt_E);
  assign w_m_rs_D = (reg_id_M != C_REG_ZERO) && (reg_id_M == rs_D);
  assign w_m_rt_D = (reg_id_M != C_REG_ZERO) && (reg_id_M == rt_D);
  assign w_e_rs_D = (reg_id_E != C_REG_ZERO) && (reg_id_E == rs_D);
  assign w_e_rt_D = (reg_id_E != C_REG_ZERO) && (reg_id_E == rt_D);

  always_comb begin
    forwardA_E = 2'b00;
    if (reg_write_M && w_m_rs_E)      forwardA_E = 2'b10;
    else if (reg_write_W && w_w_rs_E) forwardA_E = 2'b01;
  end

  always_comb begin
    forwardB_E = 2'b00;
    if (reg_write_M && w_m_rt_E)      forwardB_E = 2'b10;
    else if (reg_write_W && w_w_rt_E) forwardB_E = 2'b01;
  end

  assign forwardA_D = reg_write_M && w_m_rs_D;
  assign forwardB_D = reg_write_M && w_m_rt_D;

  logic w_lw_stall;
  logic w_br_stall;
  logic w_md_stall;
  logic w_stall;

  assign w_lw_stall = mem_to_reg_E && (w_e_rs_D || w_e_rt_D);
  assign w_br_stall = branch_D &&
                      ((reg_write_E && (w_e_rs_D || w_e_rt_D)) ||
                       (mem_to_reg_M && (w_m_rs_D || w_m_rt_D)));
  assign w_md_stall = md_use_D && md_busy;

  // Reset forces a clean pipeline: no holds, both D and E registers cleared.
  assign w_stall = (w_lw_stall || w_br_stall || w_md_stall) && !reset;

  assign stall_F = w_stall;
  assign stall_D = w_stall;
  assign flush_E = reset || w_stall;
  assign flush_D = reset || ((pc_src_D || jump_D) && !w_stall);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_md_cnt <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  // A start seen while BUSY is ignored; the running count is never reloaded.
  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    case (r_state)
      S_IDLE: begin
        if (md_start_E) begin
          w_state_nxt  = S_BUSY;
          w_md_cnt_nxt = C_MD_RELOAD;
        end
      end
      S_BUSY: begin
        if (r_md_cnt != 4'd0) w_md_cnt_nxt = r_md_cnt - 4'd1;
        else                  w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    md_busy = (r_state == S_BUSY);
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (flush_D) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

`default_nettype wire
